// File: rtl/vram1_fetcher.sv
// Row tile fetcher: streams TILES words from the dual-bank VRAM into a 2-deep
// output FIFO, while CPU writes pre-empt the shared bank port on any cycle.
module vram1_fetcher #(
    parameter int TILES = 64
) (
    input  logic        i_MCLK,
    input  logic        i_RST_n,
    input  logic        i_ROW_START,
    input  logic [11:0] i_ROW_BASE,
    output logic        o_BUSY,
    output logic [11:0] o_VRAM_ADDR,
    output logic [15:0] o_VRAM_DIN,
    output logic        o_VRAM_WR_n,
    output logic        o_VRAM_RD_n,
    input  logic [15:0] i_VRAM_DOUT,
    output logic [15:0] o_TILE_DATA,
    output logic [5:0]  o_TILE_IDX,
    output logic        o_TILE_VALID,
    input  logic        i_TILE_READY,
    input  logic        i_CPU_WR_REQ,
    input  logic [11:0] i_CPU_ADDR,
    input  logic [15:0] i_CPU_DATA,
    output logic        o_CPU_WR_ACK,
    output logic [1:0]  o_DBG_STATE
);
    // Tile stream handshake: a word moves when o_TILE_VALID && i_TILE_READY
    // at a rising edge; VALID never drops and DATA/IDX never change until then.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [11:0] addr_q, addr_d;
    logic [6:0]  issued_q, issued_d;
    logic [5:0]  idx_q, idx_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        pend_q;
    logic        rd_ptr_q, wr_ptr_q;
    logic [15:0] fifo_data_q [2];
    logic [5:0]  fifo_idx_q  [2];

    logic cpu_grant, rd_issue, push, pop, row_go, last_issue;

    // A read is only issued when its returning word is guaranteed a FIFO slot.
    assign cpu_grant  = i_RST_n && i_CPU_WR_REQ;
    assign rd_issue   = i_RST_n && !i_CPU_WR_REQ && (state_q == FETCH) &&
                        (({1'b0, cnt_q} + {2'b00, pend_q}) < 3'd2);
    assign push       = pend_q;
    assign pop        = o_TILE_VALID && i_TILE_READY;
    assign row_go     = (state_q == IDLE) && i_ROW_START;
    assign last_issue = rd_issue && (issued_q == 7'(TILES - 1));

    always_ff @(posedge i_MCLK) begin
        if (!i_RST_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_ROW_START) state_d = FETCH;
            FETCH:   if (last_issue) state_d = DRAIN;
            DRAIN:   if (!pend_q && (cnt_d == 2'd0)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        addr_d   = addr_q;
        issued_d = issued_q;
        idx_d    = idx_q + 6'(push);
        cnt_d    = cnt_q + {1'b0, push} - {1'b0, pop};
        if (row_go) begin
            addr_d   = i_ROW_BASE;
            issued_d = '0;
            idx_d    = '0;
        end else if (rd_issue) begin
            addr_d   = addr_q + 12'd1;
            issued_d = issued_q + 7'd1;
        end
    end

    always_ff @(posedge i_MCLK) begin
        if (!i_RST_n) begin
            addr_q   <= '0;
            issued_q <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            pend_q   <= 1'b0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                fifo_data_q[i] <= '0;
                fifo_idx_q[i]  <= '0;
            end
        end else begin
            addr_q   <= addr_d;
            issued_q <= issued_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            pend_q   <= rd_issue;
            rd_ptr_q <= rd_ptr_q ^ pop;
            wr_ptr_q <= wr_ptr_q ^ push;
            if (push) begin
                fifo_data_q[wr_ptr_q] <= i_VRAM_DOUT;
                fifo_idx_q[wr_ptr_q]  <= idx_q;
            end
        end
    end

    always_comb begin
        o_VRAM_ADDR  = '0;
        o_VRAM_DIN   = '0;
        o_VRAM_WR_n  = 1'b1;
        o_VRAM_RD_n  = 1'b1;
        o_CPU_WR_ACK = 1'b0;
        if (cpu_grant) begin
            o_VRAM_ADDR  = i_CPU_ADDR;
            o_VRAM_DIN   = i_CPU_DATA;
            o_VRAM_WR_n  = 1'b0;
            o_CPU_WR_ACK = 1'b1;
        end else if (rd_issue) begin
            o_VRAM_ADDR = addr_q;
            o_VRAM_RD_n = 1'b0;
        end
    end

    assign o_BUSY       = (state_q != IDLE);
    assign o_TILE_VALID = (cnt_q != 2'd0);
    assign o_TILE_DATA  = o_TILE_VALID ? fifo_data_q[rd_ptr_q] : 16'h0000;
    assign o_TILE_IDX   = o_TILE_VALID ? fifo_idx_q[rd_ptr_q] : 6'd0;
    assign o_DBG_STATE  = state_q;

endmodule

// File: doc/vram1_fetcher.md
VRAM1_FETCHER -- requirements
Module: vram1_fetcher

Interface
REQ-001 SHALL have parameter TILES, default 64: number of 16-bit tile words fetched per row (range 1..64).
REQ-002 SHALL have port i_MCLK  in  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port i_RST_n  in  1  reset, synchronous, active-low.
REQ-004 SHALL have port i_ROW_START  in  1  one-cycle pulse that starts a row fetch.
REQ-005 SHALL have port i_ROW_BASE  in  12  VRAM word address of the row's first tile, sampled with i_ROW_START.
REQ-006 SHALL have port o_BUSY  out  1  high while a row fetch is in progress.
REQ-007 SHALL have port o_VRAM_ADDR  out  12  shared address to the high-byte and low-byte VRAM banks.
REQ-008 SHALL have port o_VRAM_DIN  out  16  write data: [15:8] to the high bank, [7:0] to the low bank.
REQ-009 SHALL have port o_VRAM_WR_n  out  1  active-low write strobe to both banks.
REQ-010 SHALL have port o_VRAM_RD_n  out  1  active-low read strobe to both banks.
REQ-011 SHALL have port i_VRAM_DOUT  in  16  registered bank outputs {high, low}, valid one cycle after the read strobe.
REQ-012 SHALL have port o_TILE_DATA  out  16  fetched tile word.
REQ-013 SHALL have port o_TILE_IDX  out  6  tile index within the row (0..TILES-1).
REQ-014 SHALL have port o_TILE_VALID  out  1  o_TILE_DATA/o_TILE_IDX are valid.
REQ-015 SHALL have port i_TILE_READY  in  1  consumer accepts the word when it is high together with o_TILE_VALID.
REQ-016 SHALL have ports i_CPU_WR_REQ  in  1, i_CPU_ADDR  in  12, and i_CPU_DATA  in  16  for the CPU write request, held until acknowledged.
REQ-017 SHALL have port o_CPU_WR_ACK  out  1  one-cycle pulse in the cycle the CPU write strobe is driven.

Function
REQ-018 SHALL implement the states IDLE, FETCH and DRAIN.
- IDLE -> FETCH on i_ROW_START.
- FETCH -> DRAIN after TILES reads have been issued.
- DRAIN -> IDLE once the last word is accepted and nothing is in flight.
REQ-019 SHALL, on i_ROW_START in IDLE, load the read address from i_ROW_BASE, clear the issue and index counters, and raise o_BUSY in the next cycle.
REQ-020 SHALL ignore i_ROW_START in FETCH or DRAIN.
REQ-021 SHALL buffer returned words in a 2-entry output FIFO.
REQ-022 SHALL, in FETCH, issue a read (o_VRAM_RD_n=0, o_VRAM_ADDR=current address) only when FIFO occupancy plus in-flight reads is less than 2.
REQ-023 SHALL increment the read address by 1 per issued read, modulo 4096 (0xFFF wraps to 0x000).
REQ-024 SHALL capture i_VRAM_DOUT into the FIFO exactly one cycle after each issued read, tagged with an incrementing tile index.
REQ-025 SHALL present the FIFO head on o_TILE_DATA/o_TILE_IDX with o_TILE_VALID high whenever the FIFO is non-empty.
REQ-026 SHALL pop the FIFO head on o_TILE_VALID and i_TILE_READY; a capture and a pop in the same cycle leave occupancy unchanged.
REQ-027 SHALL hold o_TILE_DATA/o_TILE_IDX stable while o_TILE_VALID=1 and i_TILE_READY=0.
REQ-028 SHALL give CPU writes absolute priority in every state: when i_CPU_WR_REQ=1 the cycle drives o_VRAM_WR_n=0, o_VRAM_RD_n=1, o_VRAM_ADDR=i_CPU_ADDR, o_VRAM_DIN=i_CPU_DATA and o_CPU_WR_ACK=1, and no read is issued in that cycle.
REQ-029 SHALL never assert o_VRAM_RD_n and o_VRAM_WR_n low in the same cycle.
REQ-030 SHALL grant at most one CPU write per cycle; a request held for k cycles receives k acknowledges, so the CPU deasserts i_CPU_WR_REQ after the ack it wants.
REQ-031 SHALL drop o_BUSY in the cycle after the last word is accepted.
REQ-032 SHALL drive o_VRAM_ADDR=0, o_VRAM_DIN=0 and both strobes high when idle with no CPU request.

Reset
REQ-033 SHALL, with i_RST_n=0 at a clock edge, enter IDLE and empty the FIFO.
REQ-034 SHALL, under the same reset, clear the in-flight count and drive o_BUSY=0, o_TILE_VALID=0, o_CPU_WR_ACK=0, o_VRAM_RD_n=1, o_VRAM_WR_n=1, o_VRAM_ADDR=0, o_VRAM_DIN=0, o_TILE_DATA=0 and o_TILE_IDX=0.
REQ-035 SHALL discard, after a reset taken mid-fetch, any read data that returns in the cycle after reset, and issue no reads until the next i_ROW_START.

Verification
REQ-036 SHALL cover a basic row fetch: TILES=4, ROW_BASE=0x100, i_TILE_READY=1, VRAM word at A = A -> words 0x0100..0x0103 with IDX 0..3, first o_TILE_VALID 2 cycles after o_BUSY rises, o_BUSY low after IDX 3 is accepted.
REQ-037 SHALL cover address wrap: TILES=4, ROW_BASE=0xFFE -> read addresses 0xFFE, 0xFFF, 0x000, 0x001.
REQ-038 SHALL cover backpressure: i_TILE_READY=0 for 10 cycles mid-row -> at most 2 words buffered, no reads issued while occupancy plus in-flight equals 2, data held stable, and no loss or duplication after release.
REQ-039 SHALL cover a CPU write collision: i_CPU_WR_REQ held 1 cycle during FETCH with addr 0x123 and data 0xBEEF -> o_VRAM_WR_n=0, o_CPU_WR_ACK=1, no read strobe that cycle, and the fetch sequence resumes with no skipped address.
REQ-040 SHALL cover reset mid-row: i_RST_n=0 for 1 cycle after 2 of 4 reads -> all outputs at reset values, no o_TILE_VALID afterwards, and a new i_ROW_START fetches correctly from IDX 0.
